// File: rtl/mult_div_pkg.sv
// Shared op codes, FSM state encodings and small decode helpers for the
// iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // Multi-cycle ops occupy the low half of the op space.
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration on {acc, q}: shift-add for multiply, restoring
// subtract-shift for divide. Purely combinational.
module mult_div_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem_sh   = {acc, q[WIDTH-1]};
    diff     = rem_sh - {1'b0, m};
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    if (is_div) begin
      // Top bit of diff is the borrow: set means the trial subtract failed.
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_sh[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// MTHI/MTLO writes and a combinational MFHI/MFLO read port.
//
// state    | meaning
// MDU_IDLE | waiting for start; MTHI/MTLO handled here in one cycle
// MDU_RUN  | one multiply/divide step per cycle, WIDTH steps total
// MDU_FIX  | sign correction and HI/LO commit, then back to idle
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, q, m, in1_r;
  logic [WIDTH-1:0] acc_next, q_next;
  logic             is_div_r, neg_q, neg_r, dz_r;
  logic             accept, accept_arith;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign busy         = (state != MDU_IDLE);
  assign accept       = start & ~busy;
  assign accept_arith = accept & is_arith(op);

  assign sign_a = is_signed_op(op) & In1[WIDTH-1];
  assign sign_b = is_signed_op(op) & In2[WIDTH-1];
  assign mag_a  = sign_a ? -In1 : In1;
  assign mag_b  = sign_b ? -In2 : In2;

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_r),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (accept_arith) state_next = MDU_RUN;
      MDU_RUN:  if (count == '0) state_next = MDU_FIX;
      MDU_FIX:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // Divide-by-zero overrides whatever the iteration left in acc/q.
  always_comb begin
    prod   = neg_q ? -{acc, q} : {acc, q};
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (dz_r) begin
      fix_hi = in1_r;
      fix_lo = '1;
    end else if (is_div_r) begin
      fix_hi = neg_r ? -acc : acc;
      fix_lo = neg_q ? -q : q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      in1_r       <= '0;
      is_div_r    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_r        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept_arith) begin
            count       <= CW'(WIDTH - 1);
            acc         <= '0;
            in1_r       <= In1;
            is_div_r    <= is_div_op(op);
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            dz_r        <= is_div_op(op) && (In2 == '0);
            div_by_zero <= 1'b0;
            // Multiply iterates over the multiplier; divide over the dividend.
            q           <= is_div_op(op) ? mag_a : mag_b;
            m           <= is_div_op(op) ? mag_b : mag_a;
          end else if (accept && (op == MDU_MTHI)) begin
            hi <= In1;
          end else if (accept && (op == MDU_MTLO)) begin
            lo <= In1;
          end
        end
        MDU_RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count - 1'b1;
        end
        MDU_FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= dz_r;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (op == MDU_MFHI)      result = hi;
    else if (op == MDU_MFLO) result = lo;
  end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] In1, In2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo, result;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mult_div #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .In1(In1), .In2(In2),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint      sa, sb, sq, sr, sp;
    logic [63:0] up;
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      MDU_MULT: begin
        sp = sa * sb;
        eh = sp[63:32];
        el = sp[31:0];
      end
      MDU_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      default: begin
        if (b == '0) begin
          edz = 1'b1;
          eh  = a;
          el  = '1;
        end else if (o == MDU_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          eh = sr[31:0];
          el = sq[31:0];
        end else begin
          eh = a % b;
          el = a / b;
        end
      end
    endcase
  endtask

  // Issues one MULT/DIV at the current cycle and follows it to done.
  task automatic run_arith(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit disturb);
    logic [W-1:0] eh, el;
    logic         edz;
    int           cyc, busy_cnt;
    bit           seen;
    model(o, a, b, eh, el, edz);
    start = 1'b1; op = o; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_low_after_accept", 64'(done), 64'(0));
    check("dz_cleared_at_accept", 64'(div_by_zero), 64'(0));
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 100) begin
      if (busy) busy_cnt++;
      if (disturb && cyc == 4) begin
        start = 1'b1; op = MDU_MTHI; In1 = 32'h1234; In2 = ~b;
      end
      if (disturb && cyc == 5) begin
        start = 1'b0; op = MDU_MFHI; In1 = $urandom; In2 = $urandom;
      end
      if (disturb && cyc == 6) check("mfhi_during_busy", 64'(result), 64'(m_hi));
      if (cyc == W) check("hilo_hold_before_fix", {hi, lo}, {m_hi, m_lo});
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1;
    end
    check("latency", 64'(cyc), 64'(W + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
    check("busy_low_at_done", 64'(busy), 64'(0));
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic run_mt(input bit to_hi, input logic [W-1:0] v);
    start = 1'b1; op = to_hi ? MDU_MTHI : MDU_MTLO; In1 = v; In2 = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    if (to_hi) m_hi = v; else m_lo = v;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
    check("mt_no_done", 64'(done), 64'(0));
    check("mt_no_busy", 64'(busy), 64'(0));
  endtask

  task automatic read_back();
    op = MDU_MFHI; #1;
    check("mfhi", 64'(result), 64'(m_hi));
    op = MDU_MFLO; #1;
    check("mflo", 64'(result), 64'(m_lo));
    op = MDU_MULT; #1;
    check("result_zero_other_op", 64'(result), 64'(0));
  endtask

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b;
    bit           dn;
    reset = 1'b1; start = 1'b0; op = MDU_MULT; In1 = '0; In2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_by_zero), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    reset = 1'b0;

    run_arith(MDU_MULT, 32'hFFFFFFFE, 32'h3, 0);
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));

    run_arith(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    op = MDU_MFHI; #1;
    check("mfhi_const", 64'(result), 64'hFFFFFFFE);
    op = MDU_MFLO; #1;
    check("mflo_const", 64'(result), 64'h1);

    run_arith(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_arith(MDU_DIVU, 32'd100, 32'd7, 0);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_arith(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    run_arith(MDU_DIVU, 32'd5, 32'd0, 0);
    check("dz_const", {hi, lo, 31'b0, div_by_zero}, {32'd5, 32'hFFFFFFFF, 32'd1});
    run_arith(MDU_MULT, 32'h00012345, 32'h00000ABC, 1);
    check("disturb_const", {hi, lo}, 64'(64'h12345 * 64'hABC));
    run_mt(0, 32'hABCD);
    read_back();

    // Reset in the middle of a divide discards it entirely.
    start = 1'b1; op = MDU_DIV; In1 = 32'd1000; In2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hilo", {hi, lo}, 64'(0));
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn = 1;
    end
    check("midrst_no_done", 64'(dn), 64'(0));
    run_arith(MDU_MULT, 32'd3, 32'd4, 0);
    check("post_rst_mult", {hi, lo}, 64'd12);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = '1;
        2: begin a = 32'h80000000; b = '1; end
        3: b = 32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_arith(o, a, b, 0);
      if ($urandom_range(0, 3) == 0) run_mt(bit'($urandom_range(0, 1)), $urandom);
      read_back();
    end
    @(posedge clk); #1;
    check("final_done_low", 64'(done), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute path. Fed by the same register-file operands (In1 = rs, In2 = rt).
- Its read result goes to the writeback mux alongside the ALU result.
- Asserts busy so the control unit can stall PC/writeback during multi-cycle MULT/DIV.

Parameters:
WIDTH, 32, operand/HI/LO width (MIPS fixes 32; the bench may use 8 for exhaustive checks)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  3  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO
In1  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
In2  input  WIDTH  rt operand (divisor / multiplier)
busy  output  1  high while a MULT/DIV is in flight
done  output  1  one-cycle pulse after HI/LO commit
div_by_zero  output  1  registered; valid with done, held until next accept
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
result  output  WIDTH  combinational: hi if op=MFHI, lo if op=MFLO, else 0

Behaviour:
- Reset (sync, wins over everything):
  - state=IDLE; hi=lo=0; busy=done=div_by_zero=0.
  - Any in-flight operation is discarded; HI/LO are not updated.
- Accept: a clock edge with start=1 and busy=0. In1/In2/op are latched at accept. Later input changes have no effect.
- start while busy=1 is ignored: no queueing, no error.
- MTHI/MTLO:
  - Single cycle; hi (or lo) <= In1 at the accept edge.
  - busy stays 0; done is not pulsed.
- MFHI/MFLO:
  - Combinational read; no state change; start is irrelevant.
  - During busy, returns the pre-operation HI/LO. The control unit stalls MFHI/MFLO on busy.
- MULT/MULTU/DIV/DIVU use the FSM IDLE -> RUN -> FIX -> IDLE:
  - IDLE: on accept, load operands and set count=WIDTH-1. Signed ops convert to magnitudes and record the result signs.
  - RUN: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle. Runs exactly WIDTH cycles; leaves when count=0.
  - FIX: applies sign correction. Writes {hi,lo} = 2*WIDTH product, or lo = quotient and hi = remainder. Goes to IDLE.
  - Timing, with accept at edge N: busy=1 from N through the FIX edge N+WIDTH+1. HI/LO change at edge N+WIDTH+1. done=1 for the following cycle. Total latency is WIDTH+1 edges (33 for WIDTH=32).
  - A new start may be accepted in the same cycle that done=1.
- Arithmetic:
  - MULT: signed product. MULTU: unsigned. Full 2*WIDTH result, no truncation.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend. DIVU: unsigned.
  - Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag.
  - Divide by zero (In2=0 at accept), DIV or DIVU: lo=all ones, hi=In1, div_by_zero=1. Full latency is still taken, so timing stays uniform.
- div_by_zero is cleared at every MULT/DIV accept.

Decomposition:
- defines.vh: add MDU_* op codes (3-bit) and MDU_IDLE/MDU_RUN/MDU_FIX state encodings. Follows the existing ALU_* define style.
- Top: mult_div holds the FSM, counter, HI/LO, the read mux, and sign pre/post-processing.
- One sub-module is natural: mult_div_step. It is combinational and does one iteration: a shift-add or a restoring subtract on {acc, q}, selected by an is_div input. Unit-testable in isolation.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 -> after 33 edges, hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high exactly 1 cycle; busy high 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Next: MFHI gives result=0xFFFFFFFE, MFLO gives 0x00000001.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done. Following MULT accept clears div_by_zero.
- Start MULT, then pulse start with MTHI 0x1234 and change In1/In2 mid-run -> both ignored; final HI/LO match the original operands. MTLO 0xABCD when idle -> lo=0xABCD next edge, no done.
- Assert reset at cycle 10 of a DIV -> next edge: busy=0, hi=lo=0, done never pulses. A new MULT 3x4 then gives lo=12, hi=0.
